// File: rtl/rx_pll_phase_sequencer_if.sv
// Phase-request handshake into the RX user-clock PLL phase sequencer.
interface rx_pll_phase_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_phase0;
  logic [5:0] req_phase1;
  logic       req_inv_usrclk;
  logic       req_inv_usrclk2;

  modport master (
    output req_valid, req_phase0, req_phase1, req_inv_usrclk, req_inv_usrclk2,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_phase0, req_phase1, req_inv_usrclk, req_inv_usrclk2,
    output req_ready
  );
endinterface

// File: rtl/rx_pll_phase_sequencer.sv
// Reprograms CLKOUT0/CLKOUT1 phase of the RX user-clock PLL over DRP:
// hold PLL in reset, write four ClkReg words, release, wait for the helper active flag.
module rx_pll_phase_sequencer #(
  parameter logic [6:0]  CO0_REG1_ADDR = 7'h08,
  parameter logic [6:0]  CO0_REG2_ADDR = 7'h09,
  parameter logic [6:0]  CO1_REG1_ADDR = 7'h0A,
  parameter logic [6:0]  CO1_REG2_ADDR = 7'h0B,
  parameter int unsigned CO0_HALF      = 2,
  parameter int unsigned CO1_HALF      = 4,
  parameter int unsigned DRP_TIMEOUT   = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned RST_HOLD      = 16
) (
  input  logic                             drpclk,
  input  logic                             rst_n,
  rx_pll_phase_sequencer_if.slave          req,
  output logic                             drpen,
  output logic                             drpwe,
  output logic [6:0]                       drpaddr,
  output logic [15:0]                      drpdi,
  input  logic                             drprdy,
  output logic                             pll_rst,
  input  logic                             rx_active_in,
  output logic                             inv_rxusrclk,
  output logic                             inv_rxusrclk2,
  output logic                             busy,
  output logic                             done,
  output logic                             err_drp,
  output logic                             err_lock
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned DRP_W  = $clog2(DRP_TIMEOUT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HOLD, S_WR, S_WAIT_RDY, S_RELEASE, S_WAIT_LOCK, S_IDLE
  } state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_idx;
  logic [4:0]          r_phase0;
  logic [5:0]          r_phase1;
  logic                r_inv0, r_inv1;
  logic                r_pll_rst, r_inv_out0, r_inv_out1;
  logic                r_err_drp, r_err_lock;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [DRP_W-1:0]    r_drp_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  (* ASYNC_REG = "TRUE" *) logic r_act_meta;
  (* ASYNC_REG = "TRUE" *) logic r_act_sync;

  logic                w_accept, w_drp_to, w_lock_to;
  logic [15:0]         w_co0_reg1, w_co0_reg2, w_co1_reg1, w_co1_reg2;

  assign w_co0_reg1 = {r_phase0[2:0], 1'b0, 6'(CO0_HALF), 6'(CO0_HALF)};
  assign w_co0_reg2 = {8'h00, 2'b00, 4'b0000, r_phase0[4:3]};
  assign w_co1_reg1 = {r_phase1[2:0], 1'b0, 6'(CO1_HALF), 6'(CO1_HALF)};
  assign w_co1_reg2 = {8'h00, 2'b00, 3'b000, r_phase1[5:3]};

  assign w_accept  = (r_state == S_IDLE) && req.req_valid;
  assign w_drp_to  = (r_state == S_WAIT_RDY) && !drprdy &&
                     (r_drp_cnt == DRP_W'(DRP_TIMEOUT - 1));
  assign w_lock_to = (r_state == S_WAIT_LOCK) && !r_act_sync &&
                     (r_lock_cnt == LOCK_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge drpclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HOLD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HOLD:      if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) w_next = S_WR;
      S_WR:        w_next = S_WAIT_RDY;
      S_WAIT_RDY:  if (drprdy)        w_next = (r_idx == 2'd3) ? S_RELEASE : S_WR;
                   else if (w_drp_to) w_next = S_IDLE;
      S_RELEASE:   w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: if (r_act_sync || w_lock_to) w_next = S_IDLE;
      S_IDLE:      if (req.req_valid) w_next = S_HOLD;
      default:     w_next = S_HOLD;
    endcase
  end

  always_comb begin
    drpen   = (r_state == S_WR);
    drpwe   = drpen;
    drpaddr = '0;
    drpdi   = '0;
    // Address/data held from the write pulse until drprdy retires it.
    if (r_state == S_WR || r_state == S_WAIT_RDY) begin
      case (r_idx)
        2'd0:    begin drpaddr = CO0_REG1_ADDR; drpdi = w_co0_reg1; end
        2'd1:    begin drpaddr = CO0_REG2_ADDR; drpdi = w_co0_reg2; end
        2'd2:    begin drpaddr = CO1_REG1_ADDR; drpdi = w_co1_reg1; end
        default: begin drpaddr = CO1_REG2_ADDR; drpdi = w_co1_reg2; end
      endcase
    end
    busy          = (r_state != S_IDLE);
    req.req_ready = (r_state == S_IDLE);
    done          = (r_state == S_WAIT_LOCK) && r_act_sync;
  end

  always_ff @(posedge drpclk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_meta <= 1'b0;
      r_act_sync <= 1'b0;
      r_idx      <= '0;
      r_phase0   <= '0;
      r_phase1   <= '0;
      r_inv0     <= 1'b0;
      r_inv1     <= 1'b0;
      r_pll_rst  <= 1'b1;
      r_inv_out0 <= 1'b0;
      r_inv_out1 <= 1'b0;
      r_err_drp  <= 1'b0;
      r_err_lock <= 1'b0;
      r_hold_cnt <= '0;
      r_drp_cnt  <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_act_meta <= rx_active_in;
      r_act_sync <= r_act_meta;

      if (w_accept) begin
        r_phase0   <= req.req_phase0;
        r_phase1   <= req.req_phase1;
        r_inv0     <= req.req_inv_usrclk;
        r_inv1     <= req.req_inv_usrclk2;
        r_err_drp  <= 1'b0;
        r_err_lock <= 1'b0;
      end else begin
        if (w_drp_to)  r_err_drp  <= 1'b1;
        if (w_lock_to) r_err_lock <= 1'b1;
      end

      if (w_next == S_HOLD)    r_pll_rst <= 1'b1;
      if (w_next == S_RELEASE) begin
        r_pll_rst  <= 1'b0;
        r_inv_out0 <= r_inv0;
        r_inv_out1 <= r_inv1;
      end

      if (r_state == S_HOLD && w_next == S_WR)            r_idx <= '0;
      else if (r_state == S_WAIT_RDY && w_next == S_WR)   r_idx <= r_idx + 2'd1;

      // Each counter clears on entry; drp/lock timers start at the write pulse / reset release.
      if (w_next == S_HOLD && r_state != S_HOLD)        r_hold_cnt <= '0;
      else if (r_state == S_HOLD && r_hold_cnt != HOLD_W'(RST_HOLD))
        r_hold_cnt <= r_hold_cnt + 1'b1;

      if (w_next == S_WR && r_state != S_WR)            r_drp_cnt <= '0;
      else if ((r_state == S_WR || r_state == S_WAIT_RDY) && r_drp_cnt != DRP_W'(DRP_TIMEOUT))
        r_drp_cnt <= r_drp_cnt + 1'b1;

      if (w_next == S_RELEASE)                          r_lock_cnt <= '0;
      else if ((r_state == S_RELEASE || r_state == S_WAIT_LOCK) &&
               r_lock_cnt != LOCK_W'(LOCK_TIMEOUT))
        r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign inv_rxusrclk  = r_inv_out0;
  assign inv_rxusrclk2 = r_inv_out1;
  assign err_drp       = r_err_drp;
  assign err_lock      = r_err_lock;

endmodule

// File: tb/tb_rx_pll_phase_sequencer.sv
// Scoreboard bench for rx_pll_phase_sequencer: expected DRP writes, inversions and done pulses are
// queued by the directed stimulus and retired by an independent negedge monitor.
module tb_rx_pll_phase_sequencer;
  logic        drpclk = 1'b0;
  logic        rst_n;
  logic        drpen, drpwe, drprdy, pll_rst, rx_active_in;
  logic [6:0]  drpaddr;
  logic [15:0] drpdi;
  logic        inv_rxusrclk, inv_rxusrclk2, busy, done, err_drp, err_lock;

  always #5 drpclk = ~drpclk;

  rx_pll_phase_sequencer_if req_if();

  rx_pll_phase_sequencer #(
    .DRP_TIMEOUT (64),
    .LOCK_TIMEOUT(65535),
    .RST_HOLD    (16)
  ) dut (
    .drpclk       (drpclk),
    .rst_n        (rst_n),
    .req          (req_if.slave),
    .drpen        (drpen),
    .drpwe        (drpwe),
    .drpaddr      (drpaddr),
    .drpdi        (drpdi),
    .drprdy       (drprdy),
    .pll_rst      (pll_rst),
    .rx_active_in (rx_active_in),
    .inv_rxusrclk (inv_rxusrclk),
    .inv_rxusrclk2(inv_rxusrclk2),
    .busy         (busy),
    .done         (done),
    .err_drp      (err_drp),
    .err_lock     (err_lock)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [22:0] exp_wr[$];
  logic [1:0]  exp_inv[$];
  int          exp_done = 0;
  int          withhold_idx = -1;
  int          wr_idx = 0;
  int          pend = 0;
  logic        prev_pll = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return done;
      1:       return !pll_rst;
      2:       return drpen;
      3:       return err_drp;
      4:       return err_lock;
      default: return 1'b0;
    endcase
  endfunction

  // Counts negedges until the selected condition holds; timeout counts as a failure.
  task automatic wait_cond(input int sel, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge drpclk);
      n++;
    end while (!sig(sel) && n < maxc);
    if (!sig(sel)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_sel%0d: timeout after %0d cycles", sel, maxc);
      n = -1;
    end
  endtask

  task automatic push_seq(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    exp_wr.push_back({7'h08, d0});
    exp_wr.push_back({7'h09, d1});
    exp_wr.push_back({7'h0A, d2});
    exp_wr.push_back({7'h0B, d3});
  endtask

  task automatic issue(input logic [4:0] p0, input logic [5:0] p1, input logic i0, input logic i1);
    check("ready_before_req", req_if.req_ready, 1);
    wr_idx                  = 0;
    req_if.req_phase0       = p0;
    req_if.req_phase1       = p1;
    req_if.req_inv_usrclk   = i0;
    req_if.req_inv_usrclk2  = i1;
    req_if.req_valid        = 1'b1;
    @(negedge drpclk);
    req_if.req_valid        = 1'b0;
  endtask

  // DRP responder: drprdy one cycle, two cycles after each drpen, unless withheld.
  initial begin
    drprdy = 1'b0;
    forever begin
      @(negedge drpclk);
      drprdy = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) drprdy = 1'b1;
      end
      if (drpen && rst_n) begin
        if (wr_idx != withhold_idx) pend = 2;
        wr_idx++;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge drpclk) begin
    logic [22:0] e;
    logic [1:0]  iv;
    if (drpen) begin
      check("drpwe_eq_drpen", drpwe, 1);
      if (exp_wr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", drpaddr, drpdi);
      end else begin
        e = exp_wr.pop_front();
        check("drp_addr", drpaddr, e[22:16]);
        check("drp_data", drpdi, e[15:0]);
      end
    end
    if (done) begin
      check("done_expected", exp_done > 0, 1);
      if (exp_done > 0) exp_done--;
    end
    if (prev_pll && !pll_rst && rst_n) begin
      if (exp_inv.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_release: pll_rst fell with no release expected");
      end else begin
        iv = exp_inv.pop_front();
        check("inv_rxusrclk_at_release", inv_rxusrclk, iv[1]);
        check("inv_rxusrclk2_at_release", inv_rxusrclk2, iv[0]);
      end
    end
    prev_pll = pll_rst;
  end

  initial begin
    int n;
    rst_n                  = 1'b0;
    rx_active_in           = 1'b0;
    req_if.req_valid       = 1'b0;
    req_if.req_phase0      = '0;
    req_if.req_phase1      = '0;
    req_if.req_inv_usrclk  = 1'b0;
    req_if.req_inv_usrclk2 = 1'b0;
    repeat (3) @(negedge drpclk);

    check("rst_pll_rst", pll_rst, 1);
    check("rst_drpen", drpen, 0);
    check("rst_drpwe", drpwe, 0);
    check("rst_drpaddr", drpaddr, 0);
    check("rst_drpdi", drpdi, 0);
    check("rst_inv", {inv_rxusrclk, inv_rxusrclk2}, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", req_if.req_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", {err_drp, err_lock}, 0);

    // Initial sequence with phase 0 after reset release
    push_seq(16'h0082, 16'h0000, 16'h0104, 16'h0000);
    exp_inv.push_back(2'b00);
    exp_done++;
    wr_idx = 0;
    rst_n  = 1'b1;
    wait_cond(2, 100, n);
    check("hold_len", n, 16);
    check("pll_rst_during_writes", pll_rst, 1);
    wait_cond(1, 200, n);
    repeat (500) @(negedge drpclk);
    rx_active_in = 1'b1;
    wait_cond(0, 50, n);
    @(negedge drpclk);
    check("t1_busy_low", busy, 0);
    check("t1_pll_rst_low", pll_rst, 0);

    // phase0=13, phase1=42, inv=(1,0)
    push_seq(16'hA082, 16'h0001, 16'h4104, 16'h0005);
    exp_inv.push_back(2'b10);
    exp_done++;
    issue(5'd13, 6'd42, 1'b1, 1'b0);
    check("t2_busy", busy, 1);
    wait_cond(0, 200, n);
    @(negedge drpclk);
    check("t2_inv", {inv_rxusrclk, inv_rxusrclk2}, 2'b10);

    // DRP timeout on third write
    withhold_idx = 2;
    exp_wr.push_back({7'h08, 16'hE082});
    exp_wr.push_back({7'h09, 16'h0000});
    exp_wr.push_back({7'h0A, 16'h2104});
    issue(5'd7, 6'd9, 1'b0, 1'b0);
    repeat (3) wait_cond(2, 100, n);
    wait_cond(3, 200, n);
    check("drp_timeout_len", n, 64);
    check("t3_pll_rst_held", pll_rst, 1);
    check("t3_ready", req_if.req_ready, 1);
    check("t3_err_lock", err_lock, 0);
    repeat (20) @(negedge drpclk);
    check("t3_no_4th_write", exp_wr.size(), 0);
    withhold_idx = -1;

    // Lock timeout
    rx_active_in = 1'b0;
    repeat (4) @(negedge drpclk);
    push_seq(16'h0082, 16'h0000, 16'h0104, 16'h0000);
    exp_inv.push_back(2'b00);
    issue(5'd0, 6'd0, 1'b0, 1'b0);
    check("t4_err_drp_cleared", err_drp, 0);
    wait_cond(1, 200, n);
    wait_cond(4, 70000, n);
    check("lock_timeout_len", n, 65535);
    check("t4_pll_rst_low", pll_rst, 0);
    check("t4_ready", req_if.req_ready, 1);

    // req_valid held through busy; second request only after done
    rx_active_in = 1'b1;
    repeat (3) @(negedge drpclk);
    push_seq(16'h2082, 16'h0000, 16'h4104, 16'h0000);
    exp_inv.push_back(2'b00);
    exp_done++;
    push_seq(16'h8082, 16'h0002, 16'hE104, 16'h0007);
    exp_inv.push_back(2'b01);
    exp_done++;
    wr_idx                 = 0;
    req_if.req_phase0      = 5'd1;
    req_if.req_phase1      = 6'd2;
    req_if.req_inv_usrclk  = 1'b0;
    req_if.req_inv_usrclk2 = 1'b0;
    req_if.req_valid       = 1'b1;
    @(negedge drpclk);
    check("t5_err_lock_cleared", err_lock, 0);
    check("t5_busy", busy, 1);
    req_if.req_phase0      = 5'd20;
    req_if.req_phase1      = 6'd63;
    req_if.req_inv_usrclk2 = 1'b1;
    wait_cond(0, 200, n);
    @(negedge drpclk);
    check("t5_ready_after_done", req_if.req_ready, 1);
    wr_idx = 0;
    @(negedge drpclk);
    req_if.req_valid = 1'b0;
    check("t5_second_accepted", busy, 1);
    wait_cond(0, 200, n);
    @(negedge drpclk);
    check("t5_busy_low", busy, 0);
    check("t5_inv", {inv_rxusrclk, inv_rxusrclk2}, 2'b01);

    // Reset during WAIT_RDY of write 2
    exp_wr.push_back({7'h08, 16'hA082});
    exp_wr.push_back({7'h09, 16'h0001});
    issue(5'd13, 6'd42, 1'b1, 1'b0);
    repeat (2) wait_cond(2, 100, n);
    @(negedge drpclk);
    rst_n = 1'b0;
    #1;
    check("t6_drpen_in_reset", drpen, 0);
    check("t6_pll_rst_in_reset", pll_rst, 1);
    check("t6_busy_in_reset", busy, 1);
    repeat (3) @(negedge drpclk);
    check("t6_inv_in_reset", {inv_rxusrclk, inv_rxusrclk2}, 0);
    push_seq(16'h0082, 16'h0000, 16'h0104, 16'h0000);
    exp_inv.push_back(2'b00);
    exp_done++;
    wr_idx = 0;
    rst_n  = 1'b1;
    wait_cond(2, 100, n);
    check("t6_hold_len", n, 16);
    wait_cond(0, 300, n);
    @(negedge drpclk);
    check("t6_busy_low", busy, 0);

    check("end_wr_queue_empty", exp_wr.size(), 0);
    check("end_inv_queue_empty", exp_inv.size(), 0);
    check("end_done_outstanding", exp_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_pll_phase_sequencer.md
Name: rx_pll_phase_sequencer

Overview:
- Drives the DRP port and reset of the RX user-clock PLL (RXOUTCLK 100 MHz in; VCO 800 MHz; CLKOUT0 /4 = RXUSRCLK, CLKOUT1 /8 = RXUSRCLK2).
- Upstream of that stage. Accepts a phase request for CLKOUT0/CLKOUT1 plus inversion selects, and applies it as follows:
  - holds the PLL in reset;
  - writes the four clock-output DRP registers;
  - releases reset;
  - waits for the helper's active flag.
- Used by the clock-recovery loop to step the recovered-clock phase in 1/8-VCO units (156.25 ps).

Parameters:
- CO0_REG1_ADDR, 7'h08, DRP address of CLKOUT0 ClkReg1
- CO0_REG2_ADDR, 7'h09, DRP address of CLKOUT0 ClkReg2
- CO1_REG1_ADDR, 7'h0A, DRP address of CLKOUT1 ClkReg1
- CO1_REG2_ADDR, 7'h0B, DRP address of CLKOUT1 ClkReg2
- CO0_HALF, 2, CLKOUT0 high and low time in VCO cycles (divide 4)
- CO1_HALF, 4, CLKOUT1 high and low time in VCO cycles (divide 8)
- DRP_TIMEOUT, 64, drpclk cycles to wait for drprdy per write
- LOCK_TIMEOUT, 65535, drpclk cycles to wait for active after reset release
- RST_HOLD, 16, drpclk cycles pll_rst held before the first write

Ports:
- drpclk  in  1  sole clock; all logic is synchronous to it
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  phase request valid
- req_ready  out  1  high in IDLE only
- req_phase0  in  5  CLKOUT0 phase, 1/8-VCO steps (0..31 covers one period)
- req_phase1  in  6  CLKOUT1 phase, 1/8-VCO steps (0..63)
- req_inv_usrclk  in  1  requested RXUSRCLK inversion
- req_inv_usrclk2  in  1  requested RXUSRCLK2 inversion
- drpen  out  1  DRP enable, single-cycle pulse
- drpwe  out  1  DRP write enable; equals drpen (writes only)
- drpaddr  out  7  DRP address
- drpdi  out  16  DRP write data
- drprdy  in  1  DRP ready from PLL
- pll_rst  out  1  to helper reset input
- rx_active_in  in  1  helper active flag (RXUSRCLK2 domain, asynchronous here)
- inv_rxusrclk  out  1  registered inversion select
- inv_rxusrclk2  out  1  registered inversion select
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle pulse on successful completion
- err_drp  out  1  sticky; DRP timeout on last sequence
- err_lock  out  1  sticky; lock timeout on last sequence

Behaviour:

Reset values (rst_n low):
- pll_rst=1.
- drpen=drpwe=0, drpaddr=0, drpdi=0.
- inv_*=0, busy=1, req_ready=0, done=0, err_*=0.
- Latched phases = 0.
- FSM=HOLD; an initial sequence with phases 0 runs automatically after reset release.

Synchronization:
- rx_active_in passes through a 2-FF synchronizer (ASYNC_REG); FSM uses the synced value.

Request accept:
- Occurs in IDLE when req_valid=1; req_ready=1 only in IDLE.
- On accept, latch phase0, phase1 and both inv bits; clear err_*; go to HOLD next cycle.
- req_valid outside IDLE is ignored, not queued.

Data word encoding:
- ClkReg1 = {phase[2:0], 1'b0, HALF[5:0], HALF[5:0]}.
- ClkReg2 = {8'h00, 1'b0 edge, 1'b0 no_count, phase>>3 zero-extended to 6 bits}.

FSM states:
- HOLD: pll_rst=1. Counts RST_HOLD cycles, then goes to WR with index=0.
- WR: one-cycle drpen=drpwe=1 with addr/data for the current index (0: CO0_REG1, 1: CO0_REG2, 2: CO1_REG1, 3: CO1_REG2); then go to WAIT_RDY. drpaddr/drpdi stay stable until drprdy.
- WAIT_RDY:
  - On drprdy: if index=3, go to RELEASE; otherwise index+1 and go to WR.
  - If the counter reaches DRP_TIMEOUT without drprdy: set err_drp and go to IDLE with pll_rst held at 1.
- RELEASE: pll_rst=0. inv_* outputs update to the latched values in this cycle. Go to WAIT_LOCK.
- WAIT_LOCK:
  - On synced active=1: pulse done and go to IDLE.
  - If the counter reaches LOCK_TIMEOUT: set err_lock and go to IDLE; pll_rst stays 0.
- IDLE: busy=0, pll_rst unchanged.

Write constraints:
- Exactly one drpen per outstanding write; never more than one write in flight.
- drprdy arriving outside WAIT_RDY is ignored.

Reset mid-sequence: immediate return to reset values; the initial sequence reruns with phase 0.

Counters:
- Saturating; width sized from their parameter.
- Each counter is cleared on entry to its state.

Test Plan:
- Reset release with drprdy returned 2 cycles after each drpen and active rising 500 cycles later -> pll_rst high 16 cycles; 4 writes in order: addr 08/data 0x0082, 09/0x0000, 0A/0x0104, 0B/0x0000; pll_rst falls; done pulses once; busy falls.
- Request phase0=13, phase1=42, inv=(1,0) -> writes 0xA082, 0x0001, 0x4104, 0x0005; inv_rxusrclk=1 from the RELEASE cycle; done pulses.
- drprdy withheld on the 3rd write -> err_drp=1 exactly 64 cycles after that drpen; no 4th write; pll_rst stays 1; req_ready=1.
- rx_active_in never rises -> err_lock=1 after 65535 cycles; next accepted request clears err_lock.
- req_valid held high during busy, then a new request -> only the first request executes; the second is accepted only after done.
- rst_n asserted during WAIT_RDY of write 2 -> drpen=0 and pll_rst=1 immediately; after release, the full 4-write sequence with phase 0 runs.
